// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module      : mem_access_ctrl
// Description : Memory access controller. Latches the effective address (MAR)
//               and write data (MDR), runs one read or write transaction with a
//               ready handshake, returns read data in MDR and pulses done for
//               one cycle. A watchdog ends a stalled access with err.
// Optional    : define MEM_ACCESS_MMIO_EN to route MAR >= 16'hFE00 to the
//               single-cycle I/O port (io_en / io_rdata) instead of memory.
// Ports       : clk, rst           clock, asynchronous active-high reset
//               req, we, addr,     request from the control FSM / datapath,
//               wdata              sampled only while idle
//               busy, done, err    status: busy, 1-cycle completion, timeout
//               rdata              MDR contents
//               mem_addr/_wdata/   memory request (MAR, MDR, strobes held for
//               _en/_we            the whole access)
//               mem_rdata, mem_rdy memory response
//               io_en, io_rdata    MMIO strobe and read data
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl #(
   parameter int AW      = 16,
   parameter int DW      = 16,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] rdata,
   output logic          err,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_en,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_rdy,
   output logic          io_en,
   input  logic [DW-1:0] io_rdata
);

   localparam int CW = $clog2(TIMEOUT + 1);
   // The access that sees cnt == TIMEOUT-1 with no ready is the TIMEOUT-th one.
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t        r_state;
   logic [AW-1:0] r_mar;
   logic [DW-1:0] r_mdr;
   logic          r_we;
   logic [CW-1:0] r_cnt;
   logic          r_busy;
   logic          r_done;
   logic          r_err;
   logic          r_mem_en;
   logic          r_mem_we;

`ifdef MEM_ACCESS_MMIO_EN
   localparam logic [AW-1:0] IO_BASE = AW'(16'hFE00);
   logic r_io;
   logic r_io_en;
   logic w_is_io;
   // Decoded from the incoming address so the strobes are correct from the
   // first ACCESS cycle.
   assign w_is_io = (addr >= IO_BASE);
   assign io_en   = r_io_en;
`else
   logic w_unused_io;
   assign w_unused_io = ^io_rdata;
   assign io_en       = 1'b0;
`endif

   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign rdata     = r_mdr;
   assign mem_addr  = r_mar;
   assign mem_wdata = r_mdr;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_mar    <= '0;
         r_mdr    <= '0;
         r_we     <= 1'b0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_mem_en <= 1'b0;
         r_mem_we <= 1'b0;
`ifdef MEM_ACCESS_MMIO_EN
         r_io     <= 1'b0;
         r_io_en  <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req) begin
                  r_mar   <= addr;
                  r_we    <= we;
                  if (we) r_mdr <= wdata;
                  r_err   <= 1'b0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_ACCESS;
`ifdef MEM_ACCESS_MMIO_EN
                  r_io     <= w_is_io;
                  r_io_en  <= w_is_io;
                  r_mem_en <= ~w_is_io;
                  r_mem_we <= we & ~w_is_io;
`else
                  r_mem_en <= 1'b1;
                  r_mem_we <= we;
`endif
               end
            end

            S_ACCESS: begin
`ifdef MEM_ACCESS_MMIO_EN
               if (r_io) begin
                  // I/O access always completes in its single cycle.
                  if (!r_we) r_mdr <= io_rdata;
                  r_io_en <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else
`endif
               if (mem_rdy) begin
                  // Ready beats a simultaneous timeout, so err stays clear.
                  if (!r_we) r_mdr <= mem_rdata;
                  r_mem_en <= 1'b0;
                  r_mem_we <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end else begin
                  if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == CNT_LAST) begin
                     r_err    <= 1'b1;
                     r_mem_en <= 1'b0;
                     r_mem_we <= 1'b0;
                     r_done   <= 1'b1;
                     r_state  <= S_DONE;
                  end
               end
            end

            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               r_busy   <= 1'b0;
               r_mem_en <= 1'b0;
               r_mem_we <= 1'b0;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`timescale 1ns/1ps
`default_nettype none

module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [15:0] addr = '0;
   logic [15:0] wdata = '0;
   logic [15:0] mem_rdata = '0;
   logic        mem_rdy = 1'b0;
   logic [15:0] io_rdata = '0;
   logic        busy, done, err, mem_en, mem_we, io_en;
   logic [15:0] rdata, mem_addr, mem_wdata;

   mem_access_ctrl #(.AW(16), .DW(16), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .rdata(rdata), .err(err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_en(mem_en), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .io_en(io_en), .io_rdata(io_rdata)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // k = number of mem_en cycles before mem_rdy rises (-1 = never)
   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] mrd;
      logic [15:0] iord;
      int          k;
      logic [15:0] exp_rdata;
      logic        exp_err;
      int          exp_busy;
      int          exp_en;
      int          exp_io;
   } vec_t;

   function automatic vec_t mk(input logic w, input logic [15:0] a, input logic [15:0] wd,
                               input logic [15:0] m, input logic [15:0] io, input int k,
                               input logic [15:0] er, input logic ee, input int eb,
                               input int een, input int eio);
      vec_t v;
      v.we = w; v.addr = a; v.wdata = wd; v.mrd = m; v.iord = io; v.k = k;
      v.exp_rdata = er; v.exp_err = ee; v.exp_busy = eb; v.exp_en = een; v.exp_io = eio;
      return v;
   endfunction

   // Called at posedge+1 with the DUT idle.
   task automatic run_vec(input string tag, input vec_t v);
      int   busy_n, done_n, en_n, io_n, lat;
      logic bus_ok;
      busy_n = 0; done_n = 0; en_n = 0; io_n = 0; lat = -1; bus_ok = 1'b1;
      req = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata;
      mem_rdata = v.mrd; io_rdata = v.iord; mem_rdy = 1'b0;
      @(posedge clk); #1;
      // Scramble request inputs: the DUT must use the latched copies.
      req = 1'b0; we = ~v.we; addr = ~v.addr; wdata = ~v.wdata;
      for (int c = 1; c <= 40; c++) begin
         if (!busy) break;
         busy_n++;
         if (done) begin done_n++; lat = c; end
         if (mem_en) begin
            en_n++;
            if (mem_addr !== v.addr || mem_we !== v.we || (v.we && mem_wdata !== v.wdata))
               bus_ok = 1'b0;
         end
         if (io_en) begin
            io_n++;
            if (mem_addr !== v.addr) bus_ok = 1'b0;
         end
         mem_rdy = mem_en && (v.k >= 0) && (en_n > v.k);
         @(posedge clk); #1;
      end
      mem_rdy = 1'b0;
      check({tag, " idle_after"}, busy,     1'b0);
      check({tag, " rdata"},      rdata,    v.exp_rdata);
      check({tag, " err"},        err,      v.exp_err);
      check({tag, " busy_cycles"}, busy_n,  v.exp_busy);
      check({tag, " done_pulses"}, done_n,  1);
      check({tag, " done_cycle"}, lat,      v.exp_busy);
      check({tag, " mem_en_cycles"}, en_n,  v.exp_en);
      check({tag, " io_en_cycles"}, io_n,   v.exp_io);
      check({tag, " bus_values"}, bus_ok,   1'b1);
   endtask

   vec_t vecs[8];

   initial begin
      int   done_n, first_done, en_n;
      logic busy_c5, busy_c6, addr_ok;
      logic [15:0] rdata_c5, maddr_c6;

      // Vectors run in order; rdata on a timeout is whatever the previous vector left.
      vecs[0] = mk(1'b0, 16'h3000, 16'h0000, 16'h1234, 16'h0000,  2, 16'h1234, 1'b0,  4,  3, 0);
      vecs[1] = mk(1'b1, 16'h3001, 16'hABCD, 16'h9999, 16'h0000,  0, 16'hABCD, 1'b0,  2,  1, 0);
      vecs[2] = mk(1'b0, 16'h3002, 16'h0000, 16'h5555, 16'h0000, -1, 16'hABCD, 1'b1, 16, 15, 0);
      vecs[3] = mk(1'b0, 16'h3003, 16'h0000, 16'h0F0F, 16'h0000,  0, 16'h0F0F, 1'b0,  2,  1, 0);
      vecs[4] = mk(1'b1, 16'h0000, 16'hFFFF, 16'h1111, 16'h0000,  1, 16'hFFFF, 1'b0,  3,  2, 0);
      // ready on the same edge the watchdog would fire
      vecs[5] = mk(1'b0, 16'hFFFF, 16'h0000, 16'h8001, 16'h0000, 14, 16'h8001, 1'b0, 16, 15, 0);
`ifdef MEM_ACCESS_MMIO_EN
      vecs[6] = mk(1'b0, 16'hFE02, 16'h0000, 16'h2222, 16'h0041,  0, 16'h0041, 1'b0,  2,  0, 1);
      vecs[7] = mk(1'b1, 16'hFE00, 16'h5A5A, 16'h2222, 16'h0041, -1, 16'h5A5A, 1'b0,  2,  0, 1);
`else
      vecs[6] = mk(1'b0, 16'hFE02, 16'h0000, 16'h2222, 16'h0041,  0, 16'h2222, 1'b0,  2,  1, 0);
      vecs[7] = mk(1'b1, 16'hFE00, 16'h5A5A, 16'h2222, 16'h0041,  0, 16'h5A5A, 1'b0,  2,  1, 0);
`endif

      // Reset state, before any clock edge
      #3;
      check("rst busy",  busy,   1'b0);
      check("rst done",  done,   1'b0);
      check("rst err",   err,    1'b0);
      check("rst mem_en", mem_en, 1'b0);
      check("rst mem_we", mem_we, 1'b0);
      check("rst io_en", io_en,  1'b0);
      check("rst rdata", rdata,  16'h0000);
      check("rst mem_addr", mem_addr, 16'h0000);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) run_vec($sformatf("v%0d", i), vecs[i]);

      // req held high through a transaction: one accept, next only after DONE
      req = 1'b1; we = 1'b0; addr = 16'h4000; mem_rdata = 16'h7777; mem_rdy = 1'b0;
      @(posedge clk); #1;
      done_n = 0; first_done = -1; en_n = 0; addr_ok = 1'b1;
      busy_c5 = 1'b1; busy_c6 = 1'b0; rdata_c5 = '0; maddr_c6 = '0;
      for (int c = 1; c <= 6; c++) begin
         if (done) begin done_n++; first_done = c; end
         if (mem_en) en_n++;
         if (c <= 3 && mem_addr !== 16'h4000) addr_ok = 1'b0;
         if (c == 5) begin busy_c5 = busy; rdata_c5 = rdata; end
         if (c == 6) begin busy_c6 = busy; maddr_c6 = mem_addr; end
         mem_rdy = mem_en && (en_n > 2) && (c <= 3);
         addr = 16'h4000 + 16'(c);
         @(posedge clk); #1;
      end
      check("hold done_pulses", done_n, 1);
      check("hold done_cycle", first_done, 4);
      check("hold mar_latched", addr_ok, 1'b1);
      check("hold idle_gap", busy_c5, 1'b0);
      check("hold rdata", rdata_c5, 16'h7777);
      check("hold reaccept", busy_c6, 1'b1);
      check("hold next_mar", maddr_c6, 16'h4005);
      req = 1'b0; mem_rdata = 16'h4545; mem_rdy = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (!busy) break;
         @(posedge clk); #1;
      end
      mem_rdy = 1'b0;
      check("hold drain_idle", busy, 1'b0);
      check("hold drain_rdata", rdata, 16'h4545);

      // Reset in the middle of ACCESS
      req = 1'b1; we = 1'b0; addr = 16'h5000; mem_rdy = 1'b0;
      @(posedge clk); #1;
      req = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("midrst mem_en_before", mem_en, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("midrst mem_en", mem_en, 1'b0);
      check("midrst busy",   busy,   1'b0);
      check("midrst done",   done,   1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      done_n = 0;
      repeat (3) begin
         if (done || busy) done_n++;
         @(posedge clk); #1;
      end
      check("midrst quiet", done_n, 0);
      run_vec("post_rst", mk(1'b0, 16'h5004, 16'h0000, 16'h0BAD, 16'h0000, 1, 16'h0BAD, 1'b0, 3, 2, 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
